// File: rtl/hilo_divider_pkg.sv
// hilo_divider_pkg: shared FSM encoding and divider constants
package hilo_divider_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CYCLES = DIV_WIDTH;
  localparam logic [63:0] DIV_ZERO_Q = '1;
endpackage

// File: rtl/hilo_divider_div_step.sv
// div_step: one restoring shift-subtract step on the operand magnitudes
module div_step
  import hilo_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH:0]   div_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] diff;
  // shift in the next dividend bit, trial subtract, keep the difference when it does not borrow
  always_comb begin
    sh    = (WIDTH+1)'({rem_i, quo_i[WIDTH-1]});
    diff  = {1'b0, sh} - {1'b0, div_i};
    rem_o = diff[WIDTH+1] ? sh : diff[WIDTH:0];
    quo_o = {quo_i[WIDTH-2:0], ~diff[WIDTH+1]};
  end
endmodule

// File: rtl/hilo_divider.sv
// hilo_divider: multi-cycle signed/unsigned restoring divider producing LO (quotient) and HI (remainder)
module hilo_divider
  import hilo_divider_pkg::*;
#(
  parameter int WIDTH = DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_e           state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, quo_q, q_q, r_q, quo_n, q_fix, r_fix;
  logic [WIDTH:0]   b_q, rem_q, rem_n, a_mag, b_mag;
  logic             sq_q, sr_q, dz_q, a_neg, b_neg, last;
  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
  assign a_mag = a_neg ? -{1'b1, dividend} : {1'b0, dividend};
  assign b_mag = b_neg ? -{1'b1, divisor} : {1'b0, divisor};
  assign last  = cnt_q == CW'(WIDTH - 1);
  assign q_fix = dz_q ? DIV_ZERO_Q[WIDTH-1:0] : (sq_q ? -quo_n : quo_n);
  assign r_fix = dz_q ? a_q : WIDTH'(sr_q ? -rem_n : rem_n);
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .div_i(b_q),
    .rem_o(rem_n),
    .quo_o(quo_n)
  );
  // state register with registered status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  // next state: DONE always falls back to IDLE, starts outside IDLE are dropped
  always_comb begin
    state_d = state_q == IDLE ? (start ? CALC : IDLE) :
              state_q == CALC ? (last ? DONE : CALC) : IDLE;
  end
  // status flags decoded from the upcoming state so they leave the block registered
  always_comb begin
    busy_d = state_d == CALC;
    done_d = state_d == DONE;
  end
  // operand capture, iteration and result registration with sign fix-up on the last step
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      quo_q <= '0;
      rem_q <= '0;
      sq_q  <= 1'b0;
      sr_q  <= 1'b0;
      dz_q  <= 1'b0;
      q_q   <= '0;
      r_q   <= '0;
    end else if (state_q == IDLE && start) begin
      cnt_q <= '0;
      a_q   <= dividend;
      b_q   <= b_mag;
      quo_q <= WIDTH'(a_mag);
      rem_q <= '0;
      sq_q  <= a_neg ^ b_neg;
      sr_q  <= a_neg;
      dz_q  <= divisor == '0;
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q + 1'b1;
      quo_q <= quo_n;
      rem_q <= rem_n;
      if (last) begin
        q_q <= q_fix;
        r_q <= r_fix;
      end
    end
  end
  assign quotient  = q_q;
  assign remainder = r_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_hilo_divider.sv
// tb_hilo_divider: randomized self-checking bench against an arithmetic reference model
module tb_hilo_divider;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] quotient, remainder;
  logic        busy, done;
  int          n_chk = 0;
  int          n_err = 0;

  hilo_divider dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .is_signed(is_signed),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (s) begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // poke: 0 plain run, 5 re-pulse start with other operands in cycle 5, 10 reset in cycle 10
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int poke);
    logic [31:0] eq, er;
    int busy_bad, zero_bad, n_done, first_done;
    logic exp_busy, exp_done;
    model(a, b, s, eq, er);
    busy_bad = 0;
    zero_bad = 0;
    n_done = 0;
    first_done = 0;
    @(negedge clk);
    dividend = a;
    divisor = b;
    is_signed = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      exp_busy = (poke == 10 && c >= 11) ? 1'b0 : (c >= 1 && c <= 32);
      exp_done = poke != 10 && c == 33;
      if (busy !== exp_busy) busy_bad++;
      if (done === 1'b1) begin
        n_done++;
        if (first_done == 0) first_done = c;
      end
      if (c == 33 && poke != 10) begin
        check({tag, ":q"}, quotient, eq);
        check({tag, ":r"}, remainder, er);
      end
      if (exp_done && done !== 1'b1) busy_bad++;
      if (poke == 10 && c >= 11 && (quotient !== 0 || remainder !== 0)) zero_bad++;
      if (c == 2) begin
        dividend = $urandom;
        divisor = $urandom;
        is_signed = ~s;
      end
      if (poke == 5 && c == 5) begin
        dividend = ~a;
        divisor = b + 32'd3;
        is_signed = ~s;
        start = 1'b1;
      end
      if (poke == 5 && c == 6) start = 1'b0;
      if (poke == 10 && c == 10) reset = 1'b1;
      if (poke == 10 && c == 11) reset = 1'b0;
      @(posedge clk);
      #1;
    end
    check({tag, ":busy"}, busy_bad, 0);
    check({tag, ":done_cyc"}, first_done, poke == 10 ? 0 : 33);
    check({tag, ":done_cnt"}, n_done, poke == 10 ? 0 : 1);
    if (poke == 10) check({tag, ":zero_out"}, zero_bad, 0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic rs;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst:busy", 32'(busy), 0);
    check("rst:done", 32'(done), 0);
    check("rst:q", quotient, 0);
    check("rst:r", remainder, 0);
    do_div("u100_7", 32'd100, 32'd7, 1'b0, 0);
    do_div("s-7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 0);
    do_div("u-7_2", 32'hFFFFFFF9, 32'd2, 1'b0, 0);
    do_div("s_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 0);
    do_div("s_div0", 32'h12345678, 32'd0, 1'b1, 0);
    do_div("u_div0", 32'h12345678, 32'd0, 1'b0, 0);
    do_div("s_neg_div0", 32'hF0000000, 32'd0, 1'b1, 0);
    do_div("abort", 32'd1000, 32'd9, 1'b0, 10);
    do_div("after_abort", 32'd1000, 32'd9, 1'b0, 0);
    do_div("restart", 32'd555, 32'd11, 1'b1, 5);
    do_div("s_min_1", 32'h80000000, 32'd1, 1'b1, 0);
    do_div("u_max_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
    do_div("s7_-2", 32'd7, 32'hFFFFFFFE, 1'b1, 0);
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : 32'($urandom);
      if ($urandom_range(0, 3) == 0) rb = -rb;
      rs = 1'($urandom_range(0, 1));
      do_div($sformatf("rnd%0d", i), ra, rb, rs, 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
